// File: rtl/muldiv_ctrl_if.sv
// Signal bundle between muldiv_ctrl, the execute stage and the mult/div engines.
// The slave side is the controller. The master side is its environment: the execute stage plus both engines.
interface muldiv_ctrl_if;
    // execute-stage request
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        flush;
    logic        stall;

    // result back to the execute stage
    logic        res_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_w;
    logic        lo_w;
    logic [31:0] gpr_out;
    logic        gpr_w;

    // multiplier engine
    logic        mul_valid;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [63:0] mul_c;

    // divider engine
    logic        div_valid;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [63:0] div_c;

    modport master (
        output req_valid, req_op, req_a, req_b, hi_in, lo_in, flush,
        output mul_done, mul_c, div_done, div_c,
        input  stall, res_valid, hi_out, lo_out, hi_w, lo_w, gpr_out, gpr_w,
        input  mul_valid, mul_a, mul_b, div_valid, div_a, div_b
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, hi_in, lo_in, flush,
        input  mul_done, mul_c, div_done, div_c,
        output stall, res_valid, hi_out, lo_out, hi_w, lo_w, gpr_out, gpr_w,
        output mul_valid, mul_a, mul_b, div_valid, div_a, div_b
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO-class sequencer that shares one unsigned multiplier and one unsigned divider.
// It handles sign handling, MADD/MSUB accumulation and divide-by-zero, and returns a one-cycle result pulse.
module muldiv_ctrl (
    input logic          clk,
    input logic          resetn,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MUL   = 4'd8
    } op_t;

    state_t      state;
    op_t         op_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] res_q;
    logic        mul_valid_q;
    logic        div_valid_q;
    logic [31:0] hi_out_q;
    logic [31:0] lo_out_q;
    logic [31:0] gpr_out_q;
    logic        hi_w_q;
    logic        lo_w_q;
    logic        gpr_w_q;

    // Request decode. Odd codes 1..7 are the unsigned variants, and MUL is signed.
    logic        req_legal;
    logic        req_signed;
    logic        req_is_div;
    logic        req_div0;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        req_legal  = (bus.req_op <= 4'd8);
        req_signed = (bus.req_op == OP_MUL) || !bus.req_op[0];
        req_is_div = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU);
        req_div0   = req_is_div && (bus.req_b == 32'd0);
        a_mag      = (req_signed && bus.req_a[31]) ? -bus.req_a : bus.req_a;
        b_mag      = (req_signed && bus.req_b[31]) ? -bus.req_b : bus.req_b;
    end

    // Sign fix-up and accumulation, applied in the FIX cycle.
    logic [63:0] prod;
    logic [63:0] acc_res;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        prod    = neg_q ? -res_q : res_q;
        quo     = neg_q ? -res_q[31:0] : res_q[31:0];
        rem     = neg_r ? -res_q[63:32] : res_q[63:32];
        acc_res = prod;
        case (op_q)
            OP_MADD, OP_MADDU: acc_res = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: acc_res = {hi_q, lo_q} - prod;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            op_q        <= OP_MULT;
            hi_q        <= '0;
            lo_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            res_q       <= '0;
            mul_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            hi_out_q    <= '0;
            lo_out_q    <= '0;
            gpr_out_q   <= '0;
            hi_w_q      <= 1'b0;
            lo_w_q      <= 1'b0;
            gpr_w_q     <= 1'b0;
        end else if (bus.flush) begin
            state       <= S_IDLE;
            mul_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            hi_w_q      <= 1'b0;
            lo_w_q      <= 1'b0;
            gpr_w_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_legal) begin
                        op_q <= op_t'(bus.req_op);
                        hi_q <= bus.hi_in;
                        lo_q <= bus.lo_in;
                        a_q  <= a_mag;
                        b_q  <= b_mag;
                        if (req_div0) begin
                            // The final result is preloaded raw. Clearing the sign flags makes FIX pass it through.
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            res_q <= {bus.req_a, 32'hFFFF_FFFF};
                            state <= S_FIX;
                        end else begin
                            neg_q <= req_signed && (bus.req_a[31] ^ bus.req_b[31]);
                            neg_r <= req_signed && bus.req_a[31];
                            if (req_is_div) begin
                                div_valid_q <= 1'b1;
                                state       <= S_DIV;
                            end else begin
                                mul_valid_q <= 1'b1;
                                state       <= S_MUL;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (bus.mul_done) begin
                        res_q       <= bus.mul_c;
                        mul_valid_q <= 1'b0;
                        state       <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (bus.div_done) begin
                        res_q       <= bus.div_c;
                        div_valid_q <= 1'b0;
                        state       <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (op_q == OP_DIV || op_q == OP_DIVU) begin
                        hi_out_q <= rem;
                        lo_out_q <= quo;
                        hi_w_q   <= 1'b1;
                        lo_w_q   <= 1'b1;
                    end else if (op_q == OP_MUL) begin
                        gpr_out_q <= prod[31:0];
                        gpr_w_q   <= 1'b1;
                    end else begin
                        hi_out_q <= acc_res[63:32];
                        lo_out_q <= acc_res[31:0];
                        hi_w_q   <= 1'b1;
                        lo_w_q   <= 1'b1;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    hi_w_q  <= 1'b0;
                    lo_w_q  <= 1'b0;
                    gpr_w_q <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Engine operands stay constant from acceptance until the result is captured.
    assign bus.mul_valid = mul_valid_q;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.div_valid = div_valid_q;
    assign bus.div_a     = a_q;
    assign bus.div_b     = b_q;

    assign bus.hi_out  = hi_out_q;
    assign bus.lo_out  = lo_out_q;
    assign bus.gpr_out = gpr_out_q;
    assign bus.hi_w    = hi_w_q;
    assign bus.lo_w    = lo_w_q;
    assign bus.gpr_w   = gpr_w_q;

    // A flush in the DONE cycle suppresses the result. Stall also stays low while reset is held.
    assign bus.res_valid = (state == S_DONE) && !bus.flush;
    assign bus.stall     = resetn && bus.req_valid && req_legal && (state != S_DONE);
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: a directed vector table, a randomized run against an arithmetic
// reference model, and hand-written flush, reset and illegal-op sequences.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int mul_lat = 1;
    int div_lat = 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] gpr;
        logic        hilo_w;
        logic        gpr_w;
    } exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] gpr;
        logic        hi_w;
        logic        lo_w;
        logic        gpr_w;
        int          done_at;
        int          stall_cnt;
        bit          eng_seen;
        bit          timed_out;
        bit          one_shot;
    } obs_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [31:0] e_gpr;
        logic        e_gpr_w;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Engine models: after the configured latency, one done pulse per valid assertion.
    int mul_cnt;
    bit mul_fired;
    always @(negedge clk) begin
        if (bus.mul_valid !== 1'b1) begin
            mul_cnt      = 0;
            mul_fired    = 1'b0;
            bus.mul_done = 1'b0;
        end else if (mul_fired) begin
            bus.mul_done = 1'b0;
        end else begin
            mul_cnt++;
            if (mul_cnt >= mul_lat) begin
                bus.mul_c    = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
                bus.mul_done = 1'b1;
                mul_fired    = 1'b1;
            end
        end
    end

    int div_cnt;
    bit div_fired;
    always @(negedge clk) begin
        if (bus.div_valid !== 1'b1) begin
            div_cnt      = 0;
            div_fired    = 1'b0;
            bus.div_done = 1'b0;
        end else if (div_fired) begin
            bus.div_done = 1'b0;
        end else begin
            div_cnt++;
            if (div_cnt >= div_lat) begin
                if (bus.div_b == 32'd0) bus.div_c = 64'hDEAD_BEEF_DEAD_BEEF;
                else bus.div_c = {bus.div_a % bus.div_b, bus.div_a / bus.div_b};
                bus.div_done = 1'b1;
                div_fired    = 1'b1;
            end
        end
    end

    // Reference model: 64-bit signed/unsigned arithmetic straight from the instruction definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] up;
        logic [63:0] sp;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        up  = {32'd0, a} * {32'd0, b};
        sp  = sa * sb;
        acc = {hi, lo};
        e   = '{hi: 32'd0, lo: 32'd0, gpr: 32'd0, hilo_w: 1'b1, gpr_w: 1'b0};
        case (op)
            4'd0: {e.hi, e.lo} = sp;
            4'd1: {e.hi, e.lo} = up;
            4'd2: begin
                if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
                else begin e.lo = 32'(sa / sb); e.hi = 32'(sa % sb); end
            end
            4'd3: begin
                if (b == 32'd0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
            4'd4: {e.hi, e.lo} = acc + sp;
            4'd5: {e.hi, e.lo} = acc + up;
            4'd6: {e.hi, e.lo} = acc - sp;
            4'd7: {e.hi, e.lo} = acc - up;
            default: begin e.gpr = sp[31:0]; e.gpr_w = 1'b1; e.hilo_w = 1'b0; end
        endcase
        return e;
    endfunction

    // Issue one op, hold it while stalled, and record what the result cycle shows.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, output obs_t o);
        o = '{hi: 32'd0, lo: 32'd0, gpr: 32'd0, hi_w: 1'b0, lo_w: 1'b0, gpr_w: 1'b0,
              done_at: -1, stall_cnt: 0, eng_seen: 1'b0, timed_out: 1'b1, one_shot: 1'b0};
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.hi_in     = hi;
        bus.lo_in     = lo;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (bus.stall === 1'b1) o.stall_cnt++;
            if (bus.mul_valid === 1'b1 || bus.div_valid === 1'b1) o.eng_seen = 1'b1;
            if (bus.res_valid === 1'b1) begin
                o.hi = bus.hi_out; o.lo = bus.lo_out; o.gpr = bus.gpr_out;
                o.hi_w = bus.hi_w; o.lo_w = bus.lo_w; o.gpr_w = bus.gpr_w;
                o.done_at = c; o.timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (o.timed_out) begin
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
        end else begin
            @(negedge clk);
            #1;
            o.one_shot = (bus.res_valid === 1'b0);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input obs_t o, input int exp_done, input bit full);
        check({tag, "_timeout"}, 64'(o.timed_out), 64'd0);
        if (e.gpr_w) begin
            check({tag, "_gpr"}, 64'(o.gpr), 64'(e.gpr));
            check({tag, "_we"}, {61'd0, o.gpr_w, o.hi_w, o.lo_w}, 64'b100);
        end else begin
            check({tag, "_hilo"}, {o.hi, o.lo}, {e.hi, e.lo});
            check({tag, "_we"}, {61'd0, o.gpr_w, o.hi_w, o.lo_w}, 64'b011);
        end
        check({tag, "_latency"}, 64'(o.done_at), 64'(exp_done));
        if (full) begin
            check({tag, "_stall_cycles"}, 64'(o.stall_cnt), 64'(exp_done));
            check({tag, "_engine_used"}, 64'(o.eng_seen), 64'(exp_done != 2));
            check({tag, "_one_pulse"}, 64'(o.one_shot), 64'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hi_lo"}, {bus.hi_out, bus.lo_out}, 64'd0);
        check({tag, "_gpr_mula"}, {bus.gpr_out, bus.mul_a}, 64'd0);
        check({tag, "_mulb_diva"}, {bus.mul_b, bus.div_a}, 64'd0);
        check({tag, "_divb_flags"}, {bus.div_b, 24'd0, bus.stall, bus.res_valid, bus.hi_w,
                                     bus.lo_w, bus.gpr_w, bus.mul_valid, bus.div_valid, 1'b0}, 64'd0);
    endtask

    vec_t vecs[12];
    obs_t o;
    exp_t e;

    initial begin
        resetn        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.hi_in     = 32'd0;
        bus.lo_in     = 32'd0;
        bus.flush     = 1'b0;
        #1 resetn = 1'b0;
        #1 check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        //          op     a             b             hi_in         lo_in         lat e_hi          e_lo          e_gpr         gpr_w
        vecs[0]  = '{4'd0, 32'hFFFF_FFFD, 32'd5,        32'd0,        32'd0,        4, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd0,        1'b0};
        vecs[1]  = '{4'd2, 32'hFFFF_FFF9, 32'd2,        32'd0,        32'd0,        3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0,        1'b0};
        vecs[2]  = '{4'd3, 32'd7,        32'd2,        32'd0,        32'd0,        2, 32'd1,        32'd3,        32'd0,        1'b0};
        vecs[3]  = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'd0,        1, 32'd0,        32'h8000_0000, 32'd0,        1'b0};
        vecs[4]  = '{4'd2, 32'd9,        32'd0,        32'd0,        32'd0,        3, 32'd9,        32'hFFFF_FFFF, 32'd0,        1'b0};
        vecs[5]  = '{4'd5, 32'd1,        32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'd0,        32'd0,        32'd0,        1'b0};
        vecs[6]  = '{4'd6, 32'd2,        32'd3,        32'd0,        32'd0,        1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd0,        1'b0};
        vecs[7]  = '{4'd8, 32'hFFFF_FFFE, 32'h4000_0001, 32'd0,        32'd0,        2, 32'd0,        32'd0,        32'h7FFF_FFFE, 1'b1};
        vecs[8]  = '{4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd0,        5, 32'hFFFF_FFFE, 32'h0000_0001, 32'd0,        1'b0};
        vecs[9]  = '{4'd3, 32'd5,        32'd0,        32'd0,        32'd0,        1, 32'd5,        32'hFFFF_FFFF, 32'd0,        1'b0};
        vecs[10] = '{4'd4, 32'hFFFF_FFFF, 32'd3,        32'd0,        32'd10,       3, 32'd0,        32'd7,        32'd0,        1'b0};
        vecs[11] = '{4'd2, 32'd7,        32'hFFFF_FFFE, 32'd0,        32'd0,        2, 32'd1,        32'hFFFF_FFFD, 32'd0,        1'b0};

        foreach (vecs[i]) begin
            bit div0;
            mul_lat = vecs[i].lat;
            div_lat = vecs[i].lat;
            div0 = (vecs[i].op == 4'd2 || vecs[i].op == 4'd3) && vecs[i].b == 32'd0;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, o);
            e = '{hi: vecs[i].e_hi, lo: vecs[i].e_lo, gpr: vecs[i].e_gpr,
                  hilo_w: !vecs[i].e_gpr_w, gpr_w: vecs[i].e_gpr_w};
            compare($sformatf("vec%0d", i), e, o, div0 ? 2 : vecs[i].lat + 2, 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] hi;
            logic [31:0] lo;
            bit          div0;
            op = 4'($urandom_range(0, 8));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 9);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            hi      = $urandom;
            lo      = $urandom;
            mul_lat = $urandom_range(1, 5);
            div_lat = $urandom_range(1, 5);
            div0    = (op == 4'd2 || op == 4'd3) && b == 32'd0;
            run_op(op, a, b, hi, lo, o);
            e = model(op, a, b, hi, lo);
            compare($sformatf("rand%0d_op%0d", i, op), e, o,
                    div0 ? 2 : (((op == 4'd2) || (op == 4'd3)) ? div_lat : mul_lat) + 2, 1'b0);
        end

        // Illegal op code: no stall and no result.
        begin
            bit seen_stall = 1'b0;
            bit seen_res   = 1'b0;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd12;
            repeat (6) begin
                #1;
                if (bus.stall !== 1'b0) seen_stall = 1'b1;
                if (bus.res_valid !== 1'b0 || bus.mul_valid !== 1'b0 || bus.div_valid !== 1'b0) seen_res = 1'b1;
                @(negedge clk);
            end
            bus.req_valid = 1'b0;
            check("illegal_op_stall", 64'(seen_stall), 64'd0);
            check("illegal_op_activity", 64'(seen_res), 64'd0);
        end

        // Flush while the divider is busy, then a clean MULTU.
        begin
            bit seen_res = 1'b0;
            div_lat = 10;
            mul_lat = 2;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd2;
            bus.req_a     = 32'd100;
            bus.req_b     = 32'd7;
            @(negedge clk);
            @(negedge clk);
            #1 check("flush_div_busy", 64'(bus.div_valid), 64'd1);
            bus.flush     = 1'b1;
            bus.req_valid = 1'b0;
            @(negedge clk);
            bus.flush = 1'b0;
            #1 check("flush_div_valid_drop", {62'd0, bus.div_valid, bus.res_valid}, 64'd0);
            repeat (14) begin
                @(negedge clk);
                #1 if (bus.res_valid !== 1'b0 || bus.div_valid !== 1'b0) seen_res = 1'b1;
            end
            check("flush_no_result", 64'(seen_res), 64'd0);
            run_op(4'd1, 32'd3, 32'd4, 32'd0, 32'd0, o);
            compare("after_flush_multu", model(4'd1, 32'd3, 32'd4, 32'd0, 32'd0), o, 4, 1'b1);
        end

        // Asynchronous reset in the middle of a multiply.
        begin
            bit seen_res = 1'b0;
            mul_lat = 8;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = 4'd0;
            bus.req_a     = 32'd5;
            bus.req_b     = 32'd6;
            @(negedge clk);
            @(negedge clk);
            #1 check("reset_mid_mul_busy", 64'(bus.mul_valid), 64'd1);
            resetn = 1'b0;
            #1 check_all_zero("reset_mid_mul");
            @(negedge clk);
            bus.req_valid = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
            repeat (12) begin
                @(negedge clk);
                #1 if (bus.res_valid !== 1'b0) seen_res = 1'b1;
            end
            check("reset_no_result", 64'(seen_res), 64'd0);
            mul_lat = 1;
            run_op(4'd0, 32'd5, 32'd6, 32'd0, 32'd0, o);
            compare("after_reset_mult", model(4'd0, 32'd5, 32'd6, 32'd0, 32'd0), o, 3, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
